// File: rtl/seqdet_pkg.sv
// Shared definitions for the parametrised serial sequence detector:
// detector state enum, the length-field width helper and the reset defaults
// (which make the block a "1011" overlapping detector out of reset).
package seqdet_pkg;

   typedef enum logic [1:0] {
      FILL  = 2'd0,   // fewer than len valid bits seen since the last clear
      ARMED = 2'd1,   // enough history for a compare, last compare missed
      HIT   = 2'd2    // last accepted bit completed a match
   } state_t;

   // Width needed to hold a length value in the range 0..max_len.
   function automatic int len_w(input int max_len);
      return $clog2(max_len + 1);
   endfunction

   localparam int         DEF_MAX_LEN     = 8;
   localparam int         DEF_CNT_W       = 8;
   localparam logic [7:0] DEF_RST_PATTERN = 8'b0000_1011;
   localparam int         DEF_RST_LEN     = 4;
   localparam bit         DEF_RST_OVERLAP = 1'b1;

endpackage

// File: rtl/seqdet_hist_shift.sv
// History shift register and fill counter for the sequence detector.
// Ports: clk/rst, shift (accept xin), clear (wipe history), fill_clr (restart
// fill on a non-overlapping match), xin; outputs the registered fill and the
// candidate next values hist_n/fill_n that the top compares against.
module seqdet_hist_shift
   import seqdet_pkg::*;
#(
   parameter int MAX_LEN = DEF_MAX_LEN,
   parameter int LEN_W   = len_w(MAX_LEN)
)(
   input  logic               clk,
   input  logic               rst,
   input  logic               shift,
   input  logic               clear,
   input  logic               fill_clr,
   input  logic               xin,
   output logic [MAX_LEN-1:0] hist_n,
   output logic [LEN_W-1:0]   fill_n,
   output logic [LEN_W-1:0]   fill
);

   logic [MAX_LEN-1:0] hist;

   // Newest bit enters at [0]; fill saturates once the register is full.
   assign hist_n = {hist[MAX_LEN-2:0], xin};
   assign fill_n = (fill == LEN_W'(MAX_LEN)) ? fill : fill + 1'b1;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hist <= '0;
         fill <= '0;
      end else if (clear) begin
         hist <= '0;
         fill <= '0;
      end else if (shift) begin
         // History keeps shifting even after a non-overlapping match; only
         // fill restarts, which is what blocks reuse of the matched bits.
         hist <= hist_n;
         fill <= fill_clr ? '0 : fill_n;
      end
   end

endmodule

// File: rtl/seq_detector_param.sv
// Moore serial sequence detector with runtime-loadable pattern (1..MAX_LEN
// bits), overlap select and saturating match counter.
// Ports: clk, rst (async active-high), cfg_load/cfg_pattern/cfg_len/
// cfg_overlap (configuration, priority over data), xin_valid/xin (serial
// stream), zout (registered match), match_count, cfg_err (bad-load pulse).
// Build option SEQDET_COUNT_EN: when undefined the counter is removed and
// match_count is tied to zero.
module seq_detector_param
   import seqdet_pkg::*;
#(
   parameter int                 MAX_LEN     = DEF_MAX_LEN,
   parameter int                 CNT_W       = DEF_CNT_W,
   parameter logic [MAX_LEN-1:0] RST_PATTERN = MAX_LEN'(DEF_RST_PATTERN),
   parameter int                 RST_LEN     = DEF_RST_LEN,
   parameter bit                 RST_OVERLAP = DEF_RST_OVERLAP,
   parameter int                 LEN_W       = len_w(MAX_LEN)
)(
   input  logic               clk,
   input  logic               rst,
   input  logic               cfg_load,
   input  logic [MAX_LEN-1:0] cfg_pattern,
   input  logic [LEN_W-1:0]   cfg_len,
   input  logic               cfg_overlap,
   input  logic               xin_valid,
   input  logic               xin,
   output logic               zout,
   output logic [CNT_W-1:0]   match_count,
   output logic               cfg_err
);

   logic [MAX_LEN-1:0] pattern_q;
   logic [LEN_W-1:0]   len_q;
   logic               overlap_q;
   state_t             state_q;

   logic [MAX_LEN-1:0] hist_n;
   logic [LEN_W-1:0]   fill_n;
   logic [LEN_W-1:0]   fill;
   logic [MAX_LEN-1:0] len_mask;
   logic               accept;
   logic               cfg_ok;
   logic               match;

   // A bit arriving alongside a configuration load is dropped.
   assign accept = xin_valid & ~cfg_load;
   assign cfg_ok = (cfg_len != '0) && (cfg_len <= LEN_W'(MAX_LEN));

   // Pattern bits at or above len are don't-care.
   always_comb begin
      len_mask = '0;
      for (int i = 0; i < MAX_LEN; i++) begin
         len_mask[i] = (i < 32'(len_q));
      end
   end

   assign match = (fill_n >= len_q) && (((hist_n ^ pattern_q) & len_mask) == '0);

   seqdet_hist_shift #(
      .MAX_LEN (MAX_LEN),
      .LEN_W   (LEN_W)
   ) u_hist (
      .clk      (clk),
      .rst      (rst),
      .shift    (accept),
      .clear    (cfg_load),
      .fill_clr (match & ~overlap_q),
      .xin      (xin),
      .hist_n   (hist_n),
      .fill_n   (fill_n),
      .fill     (fill)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pattern_q <= RST_PATTERN;
         len_q     <= LEN_W'(RST_LEN);
         overlap_q <= RST_OVERLAP;
         state_q   <= FILL;
         zout      <= 1'b0;
         cfg_err   <= 1'b0;
      end else if (cfg_load) begin
         // Any load restarts detection; only a legal one changes the config.
         state_q <= FILL;
         zout    <= 1'b0;
         cfg_err <= ~cfg_ok;
         if (cfg_ok) begin
            pattern_q <= cfg_pattern;
            len_q     <= cfg_len;
            overlap_q <= cfg_overlap;
         end
      end else begin
         cfg_err <= 1'b0;
         if (accept) begin
            if (match) begin
               state_q <= HIT;
               zout    <= 1'b1;
            end else begin
               state_q <= (fill_n >= len_q) ? ARMED : FILL;
               zout    <= 1'b0;
            end
         end else begin
            // Idle cycles end a HIT; FILL and ARMED simply hold.
            if (state_q == HIT) begin
               state_q <= (fill >= len_q) ? ARMED : FILL;
            end
            zout <= 1'b0;
         end
      end
   end

`ifdef SEQDET_COUNT_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         match_count <= '0;
      end else if (cfg_load) begin
         if (cfg_ok) match_count <= '0;
      end else if (accept && match && (match_count != '1)) begin
         match_count <= match_count + 1'b1;
      end
   end
`else
   assign match_count = '0;
`endif

endmodule
